// File: rtl/cbm2_bus_sched.sv
// cbm2_bus_sched: system-bus slot scheduler for the CBM-II core.
// Splits each CPU period into two half-slots and assigns each to VIC, CPU or DMA.
// Ports:
//   clk_sys, reset_n (sync, active-low)
//   model (0=P2, 1=B2), vic_ba (low = VIC wants phase-1 slots)
//   dma_req / dma_ack      DMA / co-CPU handshake
//   cpuCycle, vidCycle, dmaCycle, vicPhase   per-slot owner strobes
//   cpu_ce, cpu_rdy, ram_req, ram_latch      timing strobes
module cbm2_bus_sched #(
    parameter int SLOT_CLKS  = 16,
    parameter int RAM_REQ_AT = 1,
    parameter int LATCH_AT   = 14,
    parameter int BA_GRACE   = 3
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic model,
    input  logic vic_ba,
    input  logic dma_req,
    output logic dma_ack,
    output logic cpuCycle,
    output logic vidCycle,
    output logic dmaCycle,
    output logic vicPhase,
    output logic cpu_ce,
    output logic cpu_rdy,
    output logic ram_req,
    output logic ram_latch
);

    localparam int CW = $clog2(SLOT_CLKS);
    localparam int BW = (BA_GRACE < 1) ? 1 : $clog2(BA_GRACE + 1);

    localparam logic [CW-1:0] LAST  = CW'(SLOT_CLKS - 1);
    localparam logic [CW-1:0] REQ   = CW'(RAM_REQ_AT);
    localparam logic [CW-1:0] LATCH = CW'(LATCH_AT);
    localparam logic [BW-1:0] GRACE = BW'(BA_GRACE);

    typedef enum logic {
        DMA_IDLE,
        DMA_OWN
    } dma_st_t;

    logic [CW-1:0] cnt;
    logic [BW-1:0] ba_cnt;
    logic          model_r;
    dma_st_t       dma_st;

    logic          wrap;
    logic [CW-1:0] cnt_n;
    logic          ph_n;
    logic          m_eff;
    logic [BW-1:0] ba_n;
    logic          stall;
    logic          elig;
    dma_st_t       dma_n;
    logic          cpu_c;
    logic          vid_c;
    logic          dma_c;
    logic          owned_n;
    logic          cpu_n;

    always_comb begin
        wrap  = (cnt == LAST);
        cnt_n = wrap ? '0 : cnt + 1'b1;
        ph_n  = ~vicPhase;
        // Model only changes at the start of a full period (into phase 0).
        m_eff = ph_n ? model_r : model;
        // Grace counter advances once per completed phase-1 slot with BA low.
        if (vic_ba)
            ba_n = '0;
        else if (!ph_n && ba_cnt != GRACE)
            ba_n = ba_cnt + 1'b1;
        else
            ba_n = ba_cnt;
        stall = !m_eff && ph_n && (ba_n == GRACE);
        // Slots the CPU (or DMA on its behalf) may use.
        elig  = m_eff || (ph_n && !stall);
        dma_n = dma_st;
        if (!dma_req)
            dma_n = DMA_IDLE;
        else if (dma_st == DMA_IDLE && elig)
            dma_n = DMA_OWN;
        vid_c = !elig;
        dma_c = elig && (dma_n == DMA_OWN);
        cpu_c = elig && (dma_n != DMA_OWN);
        owned_n = wrap ? 1'b1 : (cpuCycle | vidCycle | dmaCycle);
        cpu_n   = wrap ? cpu_c : cpuCycle;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cnt       <= '0;
            ba_cnt    <= '0;
            model_r   <= 1'b0;
            dma_st    <= DMA_IDLE;
            dma_ack   <= 1'b0;
            cpuCycle  <= 1'b0;
            vidCycle  <= 1'b0;
            dmaCycle  <= 1'b0;
            vicPhase  <= 1'b0;
            cpu_ce    <= 1'b0;
            cpu_rdy   <= 1'b1;
            ram_req   <= 1'b0;
            ram_latch <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            ram_req   <= owned_n && (cnt_n == REQ);
            ram_latch <= owned_n && (cnt_n == LATCH);
            cpu_ce    <= cpu_n && (cnt_n == LAST);
            if (wrap) begin
                vicPhase <= ph_n;
                if (!ph_n)
                    model_r <= model;
                ba_cnt   <= ba_n;
                dma_st   <= dma_n;
                dma_ack  <= (dma_n == DMA_OWN);
                cpuCycle <= cpu_c;
                vidCycle <= vid_c;
                dmaCycle <= dma_c;
                cpu_rdy  <= m_eff | vic_ba;
            end
        end
    end

endmodule

// File: tb/tb_cbm2_bus_sched.sv
// tb_cbm2_bus_sched: table-driven, scoreboarded bench for cbm2_bus_sched.
// Each table row drives inputs for one slot and states the owner of the following slot.
module tb_cbm2_bus_sched;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic model = 1'b0;
    logic vic_ba = 1'b1;
    logic dma_req = 1'b0;
    logic dma_ack, cpuCycle, vidCycle, dmaCycle, vicPhase;
    logic cpu_ce, cpu_rdy, ram_req, ram_latch;

    always #5 clk = ~clk;

    cbm2_bus_sched dut (
        .clk_sys  (clk),
        .reset_n  (reset_n),
        .model    (model),
        .vic_ba   (vic_ba),
        .dma_req  (dma_req),
        .dma_ack  (dma_ack),
        .cpuCycle (cpuCycle),
        .vidCycle (vidCycle),
        .dmaCycle (dmaCycle),
        .vicPhase (vicPhase),
        .cpu_ce   (cpu_ce),
        .cpu_rdy  (cpu_rdy),
        .ram_req  (ram_req),
        .ram_latch(ram_latch)
    );

    localparam logic [1:0] O_NO  = 2'd0;
    localparam logic [1:0] O_CPU = 2'd1;
    localparam logic [1:0] O_VID = 2'd2;
    localparam logic [1:0] O_DMA = 2'd3;

    typedef struct packed {
        logic       model;
        logic       vba;
        logic       dreq;
        logic [1:0] own;
        logic       ph;
        logic       rdy;
        logic       ack;
    } vec_t;

    typedef struct packed {
        logic cpu;
        logic vid;
        logic dma;
        logic ph;
        logic ce;
        logic rdy;
        logic req;
        logic latch;
        logic ack;
    } out_t;

    int   vecs = 0;
    int   errs = 0;
    out_t sb[$];
    vec_t tbl[$];
    vec_t cur;

    function automatic vec_t mk(input logic m, input logic b, input logic d,
                                input logic [1:0] o, input logic p,
                                input logic r, input logic a);
        vec_t t;
        t.model = m;
        t.vba   = b;
        t.dreq  = d;
        t.own   = o;
        t.ph    = p;
        t.rdy   = r;
        t.ack   = a;
        return t;
    endfunction

    // Expected outputs at in-slot cycle c of a slot described by e.
    function automatic out_t exp_at(input vec_t e, input int c);
        out_t o;
        logic owned;
        owned   = (e.own != O_NO);
        o.cpu   = (e.own == O_CPU);
        o.vid   = (e.own == O_VID);
        o.dma   = (e.own == O_DMA);
        o.ph    = e.ph;
        o.ce    = o.cpu && (c == 15);
        o.rdy   = e.rdy;
        o.req   = owned && (c == 1);
        o.latch = owned && (c == 14);
        o.ack   = e.ack;
        return o;
    endfunction

    task automatic check(input string tag);
        out_t got;
        out_t exp;
        got = {cpuCycle, vidCycle, dmaCycle, vicPhase, cpu_ce,
               cpu_rdy, ram_req, ram_latch, dma_ack};
        vecs++;
        if (sb.size() == 0) begin
            errs++;
            $display("FAIL %s: scoreboard empty, got %b", tag, got);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                errs++;
                $display("FAIL %s: cpu/vid/dma/ph/ce/rdy/req/latch/ack got %b required %b",
                         tag, got, exp);
            end
        end
    endtask

    // Drive one slot's inputs and check ncyc cycles of the current slot.
    task automatic slot(input vec_t s, input int ncyc, input bit abort,
                        input string tag);
        model   = s.model;
        vic_ba  = s.vba;
        dma_req = s.dreq;
        for (int c = 0; c < ncyc; c++)
            sb.push_back(exp_at(cur, c));
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", tag, c));
            if (abort && c == ncyc - 1)
                reset_n = 1'b0;
            @(posedge clk);
            #1;
        end
        if (!abort)
            cur = s;
    endtask

    task automatic do_reset(input int n, input string tag);
        reset_n = 1'b0;
        cur = mk(1'b0, 1'b1, 1'b0, O_NO, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < n; k++) begin
            sb.push_back(exp_at(cur, 0));
            @(negedge clk);
            check($sformatf("%s r%0d", tag, k));
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
    endtask

    initial begin
        // P2 basic
        tbl.push_back(mk(0, 1, 0, O_CPU, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, O_VID, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, O_CPU, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, O_VID, 0, 1, 0));
        // BA drop: three grace slots then stall
        tbl.push_back(mk(0, 0, 0, O_CPU, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, O_VID, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, O_CPU, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, O_VID, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, O_CPU, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, O_VID, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, O_VID, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, O_VID, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, O_CPU, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, O_VID, 0, 1, 0));
        // DMA grant and release
        tbl.push_back(mk(0, 1, 1, O_DMA, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, O_VID, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, O_DMA, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, O_VID, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, O_DMA, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, O_VID, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, O_DMA, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, O_VID, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, O_CPU, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, O_VID, 0, 1, 0));
        // DMA rise with BA fall: DMA takes grace slots
        tbl.push_back(mk(0, 0, 1, O_DMA, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, O_VID, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, O_DMA, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, O_VID, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, O_DMA, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, O_VID, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, O_VID, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, O_VID, 0, 1, 0));
        // B2: model taken into phase 0, BA ignored
        tbl.push_back(mk(1, 1, 0, O_CPU, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, O_CPU, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, O_CPU, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, O_CPU, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, O_CPU, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, O_CPU, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, O_CPU, 1, 1, 0));
        tbl.push_back(mk(1, 1, 1, O_DMA, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, O_CPU, 1, 1, 0));

        reset_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3, "reset");
        for (int i = 0; i < tbl.size(); i++)
            slot(tbl[i], 16, 1'b0, $sformatf("v%0d", i));

        // Reset at cnt=7 of a B2 CPU slot
        slot(mk(1, 1, 0, O_CPU, 1, 1, 0), 8, 1'b1, "abort");
        do_reset(3, "midreset");
        slot(mk(0, 1, 0, O_CPU, 1, 1, 0), 16, 1'b0, "post0");
        slot(mk(0, 1, 0, O_VID, 0, 1, 0), 16, 1'b0, "post1");
        slot(mk(0, 1, 0, O_CPU, 1, 1, 0), 16, 1'b0, "post2");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
